signal_watchdog_mc: RTL and testbench
=====================================

// Module: signal_watchdog_mc
// PURPOSE
//  Multi-channel, mode-selectable successor of the rx signal watchdog. Sits beside dot11 in the openofdm_rx top.
//  Monitors per-antenna IQ for DC/stuck input, SIG length out of window, and demod stuck too long.
//  On a violation it issues a fixed-length receiver_rst pulse (ORed into the dot11 reset), then a hold-off.
//  Exposes the reason and a violation counter for AXI status readback.
// PARAMETERS
//  IQ_DATA_WIDTH  16  bits per I or Q component
//  NUM_CH         2   antenna channels monitored (1..4)
//  DC_WIN_LOG2    5   DC window W = 2**DC_WIN_LOG2 samples (3..7)
//  RST_PULSE_LEN  4   receiver_rst high time, clk cycles (>=1)
//  HOLDOFF_LEN    64  post-pulse ignore time, clk cycles (>=1)
//  TIMEOUT_WIDTH  20  width of demod timeout counter/threshold
// PORTS
//  clk                input  1                        clock
//  rstn               input  1                        async active-low reset
//  enable             input  1                        0: all checks idle, counters cleared
//  iq_data            input  NUM_CH*2*IQ_DATA_WIDTH   ch k at [k*2W+:2W], I upper half, Q lower half
//  iq_valid           input  1                        one sample on all channels
//  demod_is_ongoing   input  1                        dot11 demod active
//  signal_len         input  16                       length decoded from SIG
//  sig_valid          input  1                        1-cycle strobe, signal_len valid
//  check_en           input  3                        [0] DC, [1] length, [2] timeout
//  min_signal_len_th  input  16                       length < min is a violation
//  max_signal_len_th  input  16                       length > max is a violation; 0 disables max
//  dc_running_sum_th  input  8                        DC imbalance threshold
//  demod_timeout_th   input  TIMEOUT_WIDTH            cycles; 0 disables
//  receiver_rst       output 1                        reset pulse to receiver
//  rst_reason         output 3                        bitmask of checks that fired last event
//  rst_count          output 16                       events since reset, saturating at 0xFFFF
// BEHAVIOUR
//  - Reset (async): all outputs 0, FSM IDLE, all counters 0. Pulse is cut immediately.
//  - FSM IDLE -> PULSE on any trig in a cycle: receiver_rst=1 from the next cycle for exactly RST_PULSE_LEN cycles.
//    PULSE -> HOLDOFF for HOLDOFF_LEN cycles -> IDLE.
//  - trig is evaluated only in IDLE with enable=1. Triggers in PULSE/HOLDOFF are dropped, not queued.
//  - On trig: rst_reason <= trig bitmask (all checks firing that cycle, e.g. 3'b110); rst_count +1 once per event.
//    rst_reason holds until the next event.
//  - DC check (bit0):
//    * Shared window counter counts iq_valid while demod_is_ongoing=1.
//    * Per channel, count negative-I (MSB=1) and negative-Q samples.
//    * At the W-th strobe: imbalance = |2*neg - W| (width DC_WIN_LOG2+1).
//    * Fires if, for ANY channel, both I and Q imbalance >= dc_running_sum_th.
//    * Window and counts then clear.
//    * All DC counters clear when demod_is_ongoing=0, enable=0, or state!=IDLE.
//  - Length check (bit1): on sig_valid, fires if signal_len < min OR (max!=0 AND signal_len > max). Unsigned compare.
//  - Timeout check (bit2):
//    * Counter +1 each cycle demod_is_ongoing=1; clears when it is 0 or state!=IDLE; saturates.
//    * Fires when th!=0 and counter+1 == th, i.e. on the th-th consecutive ongoing cycle.
//  - check_en bit low masks that check's trig. Its counters still clear as above.
//  - enable falling during PULSE/HOLDOFF: sequence completes normally.
// TESTING
//  1. en=3'b010, min=14, max=1600, sig_valid with len=2000
//     -> receiver_rst high cycles +1..+4, reason=010, count=1. len=100 -> no pulse.
//  2. NUM_CH=2, W=32, th=24, demod=1, ch1 I=+100 Q=+100 for 32 strobes, ch0 random
//     -> pulse after 32nd strobe, reason=001. Both channels random signs -> no pulse.
//  3. th=1000, demod held high -> pulse starts cycle 1001, reason=100.
//     demod drops at cycle 999 then rises -> counter restarts, no pulse before 1000 more cycles.
//  4. Length violation and timeout firing in the same cycle -> reason=110, rst_count increments by exactly 1.
//  5. Second length violation during HOLDOFF -> ignored, count unchanged.
//     Same violation 1 cycle after HOLDOFF ends -> new pulse.
//  6. rstn low in 2nd pulse cycle -> receiver_rst, rst_reason, rst_count = 0 same cycle.
//     Release -> IDLE, no spurious pulse.

Source files
------------

// File: rtl/signal_watchdog_mc.sv
// -----------------------------------------------------------------------------
// signal_watchdog_mc
//   Multi-channel receiver watchdog. It sits beside the dot11 demodulator and
//   watches for three failures:
//     bit0 DC      - on any channel, both the I and the Q sign balance over a
//                    window of 2**DC_WIN_LOG2 samples are badly skewed
//                    (DC offset or stuck input)
//     bit1 length  - the SIG length is outside [min, max] (max==0 disables max)
//     bit2 timeout - demod has been ongoing for demod_timeout_th cycles in a row
//   When any enabled check fires in IDLE, the block drives a receiver_rst pulse
//   of RST_PULSE_LEN cycles and then ignores all checks for HOLDOFF_LEN cycles.
//   The reason bitmask and a saturating event counter are kept for status
//   readback.
//
// Ports
//   clk, rstn          clock, async active-low reset
//   enable             0 idles every check and clears its counters
//   iq_data/iq_valid   NUM_CH channels, ch k at [k*2W +: 2W], {I, Q}
//   demod_is_ongoing   dot11 demod active
//   signal_len/sig_valid  SIG length and its 1-cycle strobe
//   check_en           per-check enable mask {timeout, length, dc}
//   *_th               thresholds for the three checks
//   receiver_rst       reset pulse to the receiver
//   rst_reason         checks that fired at the last event
//   rst_count          events since reset, saturating at 0xFFFF
// -----------------------------------------------------------------------------
module signal_watchdog_mc #(
  parameter int IQ_DATA_WIDTH = 16,
  parameter int NUM_CH        = 2,
  parameter int DC_WIN_LOG2   = 5,
  parameter int RST_PULSE_LEN = 4,
  parameter int HOLDOFF_LEN   = 64,
  parameter int TIMEOUT_WIDTH = 20
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              enable,
  input  logic [NUM_CH*2*IQ_DATA_WIDTH-1:0] iq_data,
  input  logic                              iq_valid,
  input  logic                              demod_is_ongoing,
  input  logic [15:0]                       signal_len,
  input  logic                              sig_valid,
  input  logic [2:0]                        check_en,
  input  logic [15:0]                       min_signal_len_th,
  input  logic [15:0]                       max_signal_len_th,
  input  logic [7:0]                        dc_running_sum_th,
  input  logic [TIMEOUT_WIDTH-1:0]          demod_timeout_th,
  output logic                              receiver_rst,
  output logic [2:0]                        rst_reason,
  output logic [15:0]                       rst_count
);

  localparam int WIN    = 1 << DC_WIN_LOG2;
  localparam int CNT_W  = DC_WIN_LOG2 + 1;       // holds 0..WIN
  localparam int CH_W   = 2 * IQ_DATA_WIDTH;
  localparam int PH_MAX = (RST_PULSE_LEN > HOLDOFF_LEN) ? RST_PULSE_LEN : HOLDOFF_LEN;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_HOLDOFF} state_t;

  state_t            state;
  logic [PH_W-1:0]   ph_cnt;

  // |2*neg - WIN|: distance of the negative-sample count from a perfect 50/50.
  function automatic logic [CNT_W-1:0] imbalance(input logic [CNT_W-1:0] neg);
    logic [CNT_W:0] twice;
    twice = {neg, 1'b0};
    if (twice >= (CNT_W+1)'(WIN)) imbalance = CNT_W'(twice - (CNT_W+1)'(WIN));
    else                          imbalance = CNT_W'((CNT_W+1)'(WIN) - twice);
  endfunction

  // ---------------------------------------------------------------- DC check
  logic                   dc_clear, dc_strobe, win_last, dc_hit;
  logic [DC_WIN_LOG2-1:0] win_cnt;
  logic [CNT_W-1:0]       neg_i     [NUM_CH];
  logic [CNT_W-1:0]       neg_q     [NUM_CH];
  logic [CNT_W-1:0]       neg_i_nxt [NUM_CH];
  logic [CNT_W-1:0]       neg_q_nxt [NUM_CH];

  assign dc_clear  = !enable || !demod_is_ongoing || (state != ST_IDLE);
  assign dc_strobe = iq_valid && !dc_clear;
  assign win_last  = dc_strobe && (&win_cnt);

  // Counts include the current sample so the W-th strobe is judged on all W.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    dc_hit = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      neg_i_nxt[k] = neg_i[k] + CNT_W'(iq_data[k*CH_W + CH_W - 1]);
      neg_q_nxt[k] = neg_q[k] + CNT_W'(iq_data[k*CH_W + IQ_DATA_WIDTH - 1]);
      if (win_last &&
          (9'(imbalance(neg_i_nxt[k])) >= 9'(dc_running_sum_th)) &&
          (9'(imbalance(neg_q_nxt[k])) >= 9'(dc_running_sum_th)))
        dc_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: the per-channel arrays are small counters, not RAM, so they take the reset.
    if (!rstn) begin
      win_cnt <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        neg_i[k] <= '0;
        neg_q[k] <= '0;
      end
    end else if (dc_clear || win_last) begin
      win_cnt <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        neg_i[k] <= '0;
        neg_q[k] <= '0;
      end
    end else if (dc_strobe) begin
      win_cnt <= win_cnt + DC_WIN_LOG2'(1);
      for (int k = 0; k < NUM_CH; k++) begin
        neg_i[k] <= neg_i_nxt[k];
        neg_q[k] <= neg_q_nxt[k];
      end
    end
  end

  // ------------------------------------------------------------ length check
  logic len_hit;
  assign len_hit = sig_valid &&
                   ((signal_len < min_signal_len_th) ||
                    ((max_signal_len_th != 16'd0) && (signal_len > max_signal_len_th)));

  // ----------------------------------------------------------- timeout check
  logic [TIMEOUT_WIDTH-1:0] to_cnt;
  logic                     to_clear, to_hit;

  assign to_clear = !enable || !demod_is_ongoing || (state != ST_IDLE);
  // Fires on the th-th consecutive ongoing cycle: the count before this cycle is th-1.
  assign to_hit   = !to_clear && (demod_timeout_th != '0) &&
                    (({1'b0, to_cnt} + (TIMEOUT_WIDTH+1)'(1)) == {1'b0, demod_timeout_th});

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state always uses non-blocking assignments.
    if (!rstn)              to_cnt <= '0;
    else if (to_clear)      to_cnt <= '0;
    else if (to_cnt != '1)  to_cnt <= to_cnt + TIMEOUT_WIDTH'(1);
  end

  // --------------------------------------------------------------- sequencer
  logic [2:0] trig;
  logic       fire;

  assign trig = check_en & {to_hit, len_hit, dc_hit};
  assign fire = enable && (state == ST_IDLE) && (|trig);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      ph_cnt       <= '0;
      receiver_rst <= 1'b0;
      rst_reason   <= 3'b000;
      rst_count    <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fire) begin
            state        <= ST_PULSE;
            ph_cnt       <= '0;
            receiver_rst <= 1'b1;
            rst_reason   <= trig;
            if (rst_count != 16'hFFFF) rst_count <= rst_count + 16'd1;
          end
        end
        ST_PULSE: begin
          if (ph_cnt == PH_W'(RST_PULSE_LEN - 1)) begin
            state        <= ST_HOLDOFF;
            ph_cnt       <= '0;
            receiver_rst <= 1'b0;
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end
        ST_HOLDOFF: begin
          if (ph_cnt == PH_W'(HOLDOFF_LEN - 1)) state  <= ST_IDLE;
          else                                  ph_cnt <= ph_cnt + PH_W'(1);
        end
        default: begin
          state        <= ST_IDLE;
          receiver_rst <= 1'b0;
        end
      endcase
    end
  end

  // Only the sign bit of each I/Q component matters here.
  logic unused_iq;
  assign unused_iq = ^iq_data;

endmodule

// File: tb/tb_signal_watchdog_mc.sv
// -----------------------------------------------------------------------------
// tb_signal_watchdog_mc
//   Directed bench for signal_watchdog_mc with default parameters
//   (2 channels, 32-sample DC window, 4-cycle pulse, 64-cycle hold-off).
//   Inputs change 1 ns after the rising edge; outputs are read at that point,
//   so each tick() shows the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_signal_watchdog_mc;

  localparam int PULSE = 4;
  localparam int HOLD  = 64;
  localparam logic [15:0] NEG = 16'hFF9C;  // -100
  localparam logic [15:0] POS = 16'h0064;  // +100

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [63:0] iq_data;
  logic        iq_valid;
  logic        demod_is_ongoing;
  logic [15:0] signal_len;
  logic        sig_valid;
  logic [2:0]  check_en;
  logic [15:0] min_signal_len_th;
  logic [15:0] max_signal_len_th;
  logic [7:0]  dc_running_sum_th;
  logic [19:0] demod_timeout_th;
  logic        receiver_rst;
  logic [2:0]  rst_reason;
  logic [15:0] rst_count;

  int vectors     = 0;
  int miscompares = 0;
  int exp_count   = 0;

  signal_watchdog_mc dut (
    .clk               (clk),
    .rstn              (rstn),
    .enable            (enable),
    .iq_data           (iq_data),
    .iq_valid          (iq_valid),
    .demod_is_ongoing  (demod_is_ongoing),
    .signal_len        (signal_len),
    .sig_valid         (sig_valid),
    .check_en          (check_en),
    .min_signal_len_th (min_signal_len_th),
    .max_signal_len_th (max_signal_len_th),
    .dc_running_sum_th (dc_running_sum_th),
    .demod_timeout_th  (demod_timeout_th),
    .receiver_rst      (receiver_rst),
    .rst_reason        (rst_reason),
    .rst_count         (rst_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called right after the edge that accepted a trigger: checks the full pulse
  // and waits out the hold-off so the next stimulus lands in IDLE.
  task automatic finish_pulse(input string tag, input logic [2:0] reason);
    check({tag, "_rst1"},   receiver_rst, 1);
    check({tag, "_reason"}, rst_reason,   reason);
    check({tag, "_count"},  rst_count,    exp_count);
    tick(PULSE - 1);
    check({tag, "_rst4"},   receiver_rst, 1);
    tick(1);
    check({tag, "_rstoff"}, receiver_rst, 0);
    tick(HOLD);
  endtask

  // 32 strobes; mask bit i = 1 makes sample i negative. Returns with demod low.
  task automatic run_window(input string tag, input logic [31:0] m0i, input logic [31:0] m0q,
                            input logic [31:0] m1i, input logic [31:0] m1q, input bit rnd0);
    for (int i = 0; i < 32; i++) begin
      if (rnd0) iq_data[31:0] = $urandom();
      else      iq_data[31:0] = {m0i[i] ? NEG : POS, m0q[i] ? NEG : POS};
      iq_data[63:32]   = {m1i[i] ? NEG : POS, m1q[i] ? NEG : POS};
      iq_valid         = 1'b1;
      demod_is_ongoing = 1'b1;
      tick(1);
      if (i == 30) check({tag, "_early"}, receiver_rst, 0);
    end
    iq_valid         = 1'b0;
    demod_is_ongoing = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit seen;
    rstn = 1'b0; enable = 1'b1; iq_data = '0; iq_valid = 1'b0; demod_is_ongoing = 1'b0;
    signal_len = '0; sig_valid = 1'b0; check_en = 3'b000;
    min_signal_len_th = 16'd14; max_signal_len_th = 16'd1600;
    dc_running_sum_th = 8'd24; demod_timeout_th = '0;
    tick(3);
    check("reset_rst",    receiver_rst, 0);
    check("reset_reason", rst_reason,   0);
    check("reset_count",  rst_count,    0);
    rstn = 1'b1;
    tick(2);

    // ---- length check
    check_en = 3'b010;
    sig_valid = 1'b1; signal_len = 16'd2000;
    tick(1);
    sig_valid = 1'b0;
    exp_count = 1;
    finish_pulse("len_hi", 3'b010);

    sig_valid = 1'b1; signal_len = 16'd100;
    tick(1);
    sig_valid = 1'b0;
    tick(1);
    check("len_ok_rst",   receiver_rst, 0);
    check("len_ok_count", rst_count,    1);

    sig_valid = 1'b1; signal_len = 16'd13;
    tick(1);
    sig_valid = 1'b0;
    exp_count = 2;
    finish_pulse("len_lo", 3'b010);

    sig_valid = 1'b1; signal_len = 16'd14;
    tick(1);
    check("len_eq_min", receiver_rst, 0);
    signal_len = 16'd1600;
    tick(1);
    check("len_eq_max", receiver_rst, 0);
    max_signal_len_th = 16'd0; signal_len = 16'hFFFF;
    tick(1);
    sig_valid = 1'b0;
    check("len_max_off", receiver_rst, 0);
    max_signal_len_th = 16'd1600;

    // ---- violation during hold-off, then one cycle after it ends
    sig_valid = 1'b1; signal_len = 16'd2000;
    tick(1);                         // E0: pulse accepted
    sig_valid = 1'b0;
    exp_count = 3;
    check("ho_first", rst_count, 3);
    tick(PULSE + 30);                // E34
    sig_valid = 1'b1;
    tick(1);                         // E35, in hold-off
    sig_valid = 1'b0;
    check("ho_mid_rst",   receiver_rst, 0);
    check("ho_mid_count", rst_count,    3);
    tick(32);                        // E67
    sig_valid = 1'b1;
    tick(1);                         // E68, last hold-off cycle
    check("ho_last_rst", receiver_rst, 0);
    tick(1);                         // E69, back in IDLE
    sig_valid = 1'b0;
    exp_count = 4;
    finish_pulse("ho_after", 3'b010);

    // ---- DC check
    check_en = 3'b001;
    run_window("dc_ch1", 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    exp_count = 5;
    finish_pulse("dc_ch1", 3'b001);

    run_window("dc_bal", 32'h5555_5555, 32'h3333_3333, 32'h0F0F_0F0F, 32'h00FF_00FF, 1'b0);
    tick(1);
    check("dc_bal_rst", receiver_rst, 0);

    run_window("dc_ionly", 32'h5555_5555, 32'h3333_3333, 32'h0, 32'h5555_5555, 1'b0);
    tick(1);
    check("dc_ionly_rst", receiver_rst, 0);

    // 4 and 28 negatives -> imbalance exactly 24
    run_window("dc_edge", 32'h5555_5555, 32'h3333_3333, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
    exp_count = 6;
    finish_pulse("dc_edge", 3'b001);

    // 5 negatives on I -> 22, below threshold
    run_window("dc_below", 32'h5555_5555, 32'h3333_3333, 32'h0000_001F, 32'h0FFF_FFFF, 1'b0);
    tick(1);
    check("dc_below_rst", receiver_rst, 0);

    // ---- timeout check
    check_en = 3'b100; demod_timeout_th = 20'd1000;
    demod_is_ongoing = 1'b1;
    tick(999);
    check("to_999", receiver_rst, 0);
    tick(1);
    demod_is_ongoing = 1'b0;
    exp_count = 7;
    finish_pulse("to_1000", 3'b100);

    demod_is_ongoing = 1'b1;
    tick(998);
    demod_is_ongoing = 1'b0;
    tick(1);
    demod_is_ongoing = 1'b1;
    tick(999);
    check("to_restart_999", receiver_rst, 0);
    check("to_restart_cnt", rst_count,    7);
    tick(1);
    demod_is_ongoing = 1'b0;
    exp_count = 8;
    finish_pulse("to_restart", 3'b100);

    // enable low for one cycle clears the timeout counter
    demod_timeout_th = 20'd20;
    demod_is_ongoing = 1'b1;
    tick(10);
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(19);
    check("to_en_19", receiver_rst, 0);
    tick(1);
    demod_is_ongoing = 1'b0;
    exp_count = 9;
    finish_pulse("to_en", 3'b100);

    // ---- length and timeout in the same cycle
    check_en = 3'b111;
    demod_is_ongoing = 1'b1;
    tick(19);
    sig_valid = 1'b1; signal_len = 16'd2000;
    tick(1);
    sig_valid = 1'b0; demod_is_ongoing = 1'b0;
    exp_count = 10;
    finish_pulse("both", 3'b110);

    // ---- enable dropping mid-pulse, then no triggers while disabled
    check_en = 3'b010;
    sig_valid = 1'b1; signal_len = 16'd2000;
    tick(1);
    sig_valid = 1'b0; enable = 1'b0;
    exp_count = 11;
    finish_pulse("en_drop", 3'b010);
    sig_valid = 1'b1;
    tick(1);
    sig_valid = 1'b0;
    tick(1);
    check("en_off_rst",   receiver_rst, 0);
    check("en_off_count", rst_count,    11);
    enable = 1'b1;

    // ---- async reset in the second pulse cycle
    sig_valid = 1'b1; signal_len = 16'd2000;
    tick(1);
    sig_valid = 1'b0;
    tick(1);
    check("arst_pre", receiver_rst, 1);
    #2 rstn = 1'b0;
    #1;
    check("arst_rst",    receiver_rst, 0);
    check("arst_reason", rst_reason,   0);
    check("arst_count",  rst_count,    0);
    #3 rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      if (receiver_rst) seen = 1'b1;
    end
    check("arst_no_pulse", seen,      0);
    check("arst_count2",   rst_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
